alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 132 +++++++++++++
 tb/tb_alu_result_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: computes set/branch data and condition, then holds results in a 2-entry skid buffer.
// Optional overflow exception tagging is enabled by defining ALU_OFL_TRAP_EN.
module alu_result_stage #(
  parameter int OPERAND_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] alu_out,
  input  logic                     alu_ofl,
  input  logic                     alu_zero,
  input  logic                     alu_cout,
  input  logic                     alu_neg,
  input  logic [2:0]               cond_sel,
  input  logic [2:0]               dst_reg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic [2:0]               out_reg,
  output logic                     out_cond,
  output logic                     out_exc,
  input  logic                     flush
);

  // Entry layout, LSB first: data, register tag, condition, optional exception bit.
`ifdef ALU_OFL_TRAP_EN
  localparam int EW = OPERAND_WIDTH + 5;
`else
  localparam int EW = OPERAND_WIDTH + 4;
`endif

  typedef enum logic [2:0] {
    SEL_PASS = 3'b000,
    SEL_SEQ  = 3'b001,
    SEL_SLT  = 3'b010,
    SEL_SLE  = 3'b011,
    SEL_SCO  = 3'b100,
    SEL_BNEZ = 3'b101,
    SEL_BLTZ = 3'b110,
    SEL_BGEZ = 3'b111
  } cond_sel_e;

  logic [1:0]               count_q, count_d;
  logic [EW-1:0]            head_q, head_d;
  logic [EW-1:0]            tail_q, tail_d;
  logic [EW-1:0]            new_entry;
  logic [OPERAND_WIDTH-1:0] new_data;
  logic                     new_cond;
  logic                     lt;
  logic                     push;
  logic                     pop;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign lt        = alu_neg ^ alu_ofl;

  always_comb begin
    new_data = alu_out;
    new_cond = 1'b0;
    case (cond_sel_e'(cond_sel))
      SEL_PASS: new_cond = 1'b0;
      SEL_SEQ:  new_cond = alu_zero;
      SEL_SLT:  new_cond = lt;
      SEL_SLE:  new_cond = lt | alu_zero;
      SEL_SCO:  new_cond = alu_cout;
      SEL_BNEZ: new_cond = ~alu_zero;
      SEL_BLTZ: new_cond = alu_neg;
      SEL_BGEZ: new_cond = ~alu_neg;
      default:  new_cond = 1'b0;
    endcase
    // Set operations replace the data with the zero-extended condition.
    if (cond_sel inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
      new_data = {{(OPERAND_WIDTH-1){1'b0}}, new_cond};
    end
  end

`ifdef ALU_OFL_TRAP_EN
  assign new_entry = {alu_ofl & (cond_sel == 3'b000 || cond_sel[2] & (cond_sel != 3'b100)),
                      new_cond, dst_reg, new_data};
`else
  assign new_entry = {new_cond, dst_reg, new_data};
`endif

  // Flush wins over everything; push and pop together only happen at count 1.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: head_d = new_entry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_data = out_valid ? head_q[OPERAND_WIDTH-1:0] : '0;
  assign out_reg  = out_valid ? head_q[OPERAND_WIDTH+2:OPERAND_WIDTH] : 3'd0;
  assign out_cond = out_valid ? head_q[OPERAND_WIDTH+3] : 1'b0;
`ifdef ALU_OFL_TRAP_EN
  assign out_exc  = out_valid ? head_q[OPERAND_WIDTH+4] : 1'b0;
`else
  assign out_exc  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed steps plus a random tail, checked against a scoreboard queue.
// Honours ALU_OFL_TRAP_EN the same way as the design build.
module tb_alu_result_stage;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  r;
    logic        c;
    logic        e;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_ofl, alu_zero, alu_cout, alu_neg;
  logic [2:0]  cond_sel;
  logic [2:0]  dst_reg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_reg;
  logic        out_cond;
  logic        out_exc;
  logic        flush;

  ent_t sb[$];
  int   passed = 0;
  int   total  = 0;

  alu_result_stage #(.OPERAND_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_neg(alu_neg), .cond_sel(cond_sel), .dst_reg(dst_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_reg(out_reg), .out_cond(out_cond), .out_exc(out_exc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference table for the data/condition an accepted result should carry.
  function automatic ent_t model(input logic [15:0] a, input logic o, input logic z,
                                 input logic co, input logic n, input logic [2:0] s,
                                 input logic [2:0] r);
    ent_t x;
    x.r = r;
    x.e = 1'b0;
    case (s)
      3'd0: begin x.c = 1'b0;           x.d = a;          end
      3'd1: begin x.c = z;              x.d = {15'd0, z}; end
      3'd2: begin x.c = n ^ o;          x.d = {15'd0, n ^ o}; end
      3'd3: begin x.c = (n ^ o) | z;    x.d = {15'd0, (n ^ o) | z}; end
      3'd4: begin x.c = co;             x.d = {15'd0, co}; end
      3'd5: begin x.c = ~z;             x.d = a;          end
      3'd6: begin x.c = n;              x.d = a;          end
      default: begin x.c = ~n;          x.d = a;          end
    endcase
`ifdef ALU_OFL_TRAP_EN
    if (s == 3'd0 || s >= 3'd5) x.e = o;
`endif
    return x;
  endfunction

  task automatic checkOutput();
    ent_t h;
    h = (sb.size() > 0) ? sb[0] : '0;
    check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
    check("in_ready",  {31'd0, in_ready},  {31'd0, sb.size() < 2});
    check("out_data",  {16'd0, out_data},  {16'd0, h.d});
    check("out_reg",   {29'd0, out_reg},   {29'd0, h.r});
    check("out_cond",  {31'd0, out_cond},  {31'd0, h.c});
    check("out_exc",   {31'd0, out_exc},   {31'd0, h.e});
  endtask

  // Drives one cycle of inputs, advances the scoreboard, then samples 1ns after the edge.
  task automatic applyStimulus(input logic iv, input logic [15:0] a, input logic o,
                               input logic z, input logic co, input logic n,
                               input logic [2:0] s, input logic [2:0] r,
                               input logic ordy, input logic fl, input logic rs);
    bit acc, pp;
    in_valid = iv; alu_out = a; alu_ofl = o; alu_zero = z; alu_cout = co; alu_neg = n;
    cond_sel = s; dst_reg = r; out_ready = ordy; flush = fl; rst = rs;
    acc = iv && (sb.size() < 2);
    pp  = ordy && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(model(a, o, z, co, n, s, r));
    end
    checkOutput();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_out = '0; alu_ofl = 1'b0; alu_zero = 1'b0;
    alu_cout = 1'b0; alu_neg = 1'b0; cond_sel = '0; dst_reg = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset held two cycles with a valid result offered.
    repeat (2) applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check("rst_data", {16'd0, out_data}, 32'h0);
    check("rst_ready", {31'd0, in_ready}, 32'h1);

    // SLT with negative result and no overflow.
    applyStimulus(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    check("slt_data", {16'd0, out_data}, 32'h1);
    check("slt_cond", {31'd0, out_cond}, 32'h1);
    check("slt_reg",  {29'd0, out_reg},  32'h3);
    idle(1'b1);

    // Backpressure: fill, try a third push, then drain in order.
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    check("bp_full", {31'd0, in_ready}, 32'h0);
    applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    check("bp_hold", {16'd0, out_data}, 32'h1111);
    idle(1'b1);
    check("bp_second", {16'd0, out_data}, 32'h2222);
    check("bp_ready", {31'd0, in_ready}, 32'h1);
    idle(1'b1);

    // Flush at full occupancy drops the concurrently offered result.
    applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0);
    check("flush_valid", {31'd0, out_valid}, 32'h0);
    idle(1'b1);
    check("flush_gone", {16'd0, out_data}, 32'h0);

    // Overflow trap on a pass-through result.
    applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    check("ofl_data", {16'd0, out_data}, 32'h8000);
`ifdef ALU_OFL_TRAP_EN
    check("ofl_exc", {31'd0, out_exc}, 32'h1);
`else
    check("ofl_exc", {31'd0, out_exc}, 32'h0);
`endif

    // BGEZ then SLE at zero, each replacing the head in a push+pop cycle.
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0);
    check("bgez_cond", {31'd0, out_cond}, 32'h1);
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
    check("sle_data", {16'd0, out_data}, 32'h1);

    // Reset mid-operation with the buffer full.
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1);
    check("midrst_valid", {31'd0, out_valid}, 32'h0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
